ram_req_bridge: RTL and testbench

Request-side front end for the simulation RAM model. It accepts burst read/write requests from the memory interconnect over valid/ready channels and converts byte addresses into 64-bit word indices. It drives the RAM model's per-cycle read-index/write-index/data/mask/enable port and returns read data and write acknowledgements through a buffered response channel. It sits directly upstream of the RAM helper and owns all flow control, because the RAM model itself has none.

---
 rtl/ram_req_bridge.sv | 184 ++++++++++++++++++
 tb/tb_ram_req_bridge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_bridge.sv
// ram_req_bridge: valid/ready request front end for the sim RAM model.
// Serializes bursts, maps byte addresses to word indices, buffers responses.
module ram_req_bridge #(
  parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
  parameter int          RESP_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [7:0]  req_len,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [63:0] w_data,
  input  logic [7:0]  w_strb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_last,
  output logic        resp_is_write,
  output logic [63:0] ram_rIdx,
  input  logic [63:0] ram_rdata,
  output logic [63:0] ram_wIdx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  output logic        ram_wen
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    WRESP
  } state_t;

  state_t state, state_n;

  logic [63:0] idx;
  logic [63:0] ridx_q;
  logic [7:0]  beat_cnt;
  logic [7:0]  len;
  logic        stage_valid;
  logic        stage_last;

  logic [63:0] f_data [RESP_DEPTH];
  logic        f_last [RESP_DEPTH];
  logic        f_wr   [RESP_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;

  logic        accept;
  logic        issue;
  logic        wfire;
  logic        last_beat;
  logic        push;
  logic        pop;
  logic        push_last;
  logic        push_wr;
  logic [63:0] push_data;
  logic [63:0] mask;

  assign last_beat = beat_cnt == len;
  assign accept    = req_valid && req_ready;
  // Beats already buffered or in flight; same-cycle pops are ignored.
  assign occ = {1'b0, count} + (CW+1)'(stage_valid);

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    w_ready   = 1'b0;
    issue     = 1'b0;
    wfire     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !reset && count == '0
                    && !stage_valid;
        if (req_valid && req_ready)
          state_n = req_wen ? WRITE : READ;
      end
      READ: begin
        issue = occ < (CW+1)'(RESP_DEPTH);
        if (issue && last_beat)
          state_n = IDLE;
      end
      WRITE: begin
        w_ready = 1'b1;
        wfire   = w_valid;
        if (wfire && last_beat)
          state_n = WRESP;
      end
      WRESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < 8; i++)
      mask[8*i +: 8] = {8{w_strb[i]}};
  end

  assign ram_rIdx  = issue ? idx : ridx_q;
  assign ram_wen   = wfire;
  assign ram_wIdx  = wfire ? idx : '0;
  assign ram_wdata = wfire ? w_data : '0;
  assign ram_wmask = wfire ? mask : '0;

  assign push      = stage_valid || state == WRESP;
  assign push_data = stage_valid ? ram_rdata : '0;
  assign push_last = stage_valid ? stage_last : 1'b1;
  assign push_wr   = !stage_valid;

  assign resp_valid    = count != '0;
  assign pop           = resp_valid && resp_ready;
  assign resp_data     = f_data[rd_ptr];
  assign resp_last     = f_last[rd_ptr];
  assign resp_is_write = f_wr[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      ridx_q      <= '0;
      beat_cnt    <= '0;
      len         <= '0;
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
    end else begin
      if (accept) begin
        idx      <= (req_addr >> 3)
                    - (ADDR_BASE >> 3);
        beat_cnt <= '0;
        len      <= req_len;
      end else if (issue || wfire) begin
        idx      <= idx + 64'd1;
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (issue)
        ridx_q <= idx;
      stage_valid <= issue;
      stage_last  <= issue && last_beat;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1))
                  ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1))
                  ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      f_data[wr_ptr] <= push_data;
      f_last[wr_ptr] <= push_last;
      f_wr[wr_ptr]   <= push_wr;
    end
  end

endmodule

// File: tb/tb_ram_req_bridge.sv
// tb_ram_req_bridge: directed bursts checked against a scoreboard model
// plus literal checks on latency, word indices, masks and reset.
module tb_ram_req_bridge;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [7:0]  req_len;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_last;
  logic        resp_is_write;
  logic [63:0] ram_rIdx;
  logic [63:0] ram_rdata;
  logic [63:0] ram_wIdx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic        ram_wen;

  ram_req_bridge #(
    .ADDR_BASE (BASE),
    .RESP_DEPTH(DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_len      (req_len),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .w_strb       (w_strb),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_last    (resp_last),
    .resp_is_write(resp_is_write),
    .ram_rIdx     (ram_rIdx),
    .ram_rdata    (ram_rdata),
    .ram_wIdx     (ram_wIdx),
    .ram_wdata    (ram_wdata),
    .ram_wmask    (ram_wmask),
    .ram_wen      (ram_wen)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        w;
  } resp_t;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic ram_init;
  logic [63:0] ram [256];
  logic [63:0] mdl [256];
  logic [63:0] ridx_log [1024];

  resp_t exp_q[$];
  logic [63:0] widx_q[$];
  logic [63:0] wmask_q[$];
  resp_t last_resp;
  bit m_busy;
  bit m_wactive;
  logic [63:0] m_widx;
  int m_wleft;
  int acc_cyc;
  int first_rv_cyc;
  int first_pop_cyc;
  int last_pop_cyc;
  int last_wbeat_cyc;
  int pops;

  function automatic logic [63:0] init_word(input logic [7:0] i);
    if (i == 8'd0)
      return 64'hDEAD_BEEF_0000_0001;
    return 64'h0123_4567_0000_0000 | {56'h0, i}
           | ({56'h0, ~i} << 16);
  endfunction

  function automatic logic [63:0] expand(input logic [7:0] s);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++)
      if (s[i]) m = m | (64'hFF << (8 * i));
    return m;
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // RAM model: read data lags the presented index by one cycle.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    ram_rdata <= ram[ram_rIdx[7:0]];
    if (ram_init) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= init_word(8'(i));
    end else if (ram_wen) begin
      ram[ram_wIdx[7:0]] <= (ram[ram_wIdx[7:0]] & ~ram_wmask)
                            | (ram_wdata & ram_wmask);
    end
  end

  // Scoreboard model and per-cycle compare.
  initial begin
    logic [63:0] b;
    logic [63:0] mk;
    logic [63:0] wi;
    resp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        m_busy    = 1'b0;
        m_wactive = 1'b0;
        m_wleft   = 0;
        if (ram_init)
          for (int i = 0; i < 256; i++)
            mdl[i] = init_word(8'(i));
      end else begin
        ridx_log[cyc % 1024] = ram_rIdx;
        chk("req_ready", 64'(req_ready), 64'(!m_busy));
        chk("w_ready", 64'(w_ready), 64'(m_wactive));
        chk("ram_wen", 64'(ram_wen), 64'(m_wactive && w_valid));
        if (ram_wen) begin
          widx_q.push_back(ram_wIdx);
          wmask_q.push_back(ram_wmask);
        end
        if (m_wactive && w_valid) begin
          mk = expand(w_strb);
          chk("ram_wIdx", ram_wIdx, m_widx);
          chk("ram_wdata", ram_wdata, w_data);
          chk("ram_wmask", ram_wmask, mk);
          wi = m_widx;
          mdl[wi[7:0]] = (mdl[wi[7:0]] & ~mk) | (w_data & mk);
          m_widx = m_widx + 64'd1;
          if (m_wleft == 0) begin
            m_wactive = 1'b0;
            last_wbeat_cyc = cyc;
            exp_q.push_back('{d: 64'd0, l: 1'b1, w: 1'b1});
          end else begin
            m_wleft--;
          end
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("resp_spurious", 64'(resp_valid), 64'd0);
          end else begin
            if (first_rv_cyc < 0)
              first_rv_cyc = cyc;
            if (resp_ready) begin
              e = exp_q.pop_front();
              chk("resp_data", resp_data, e.d);
              chk("resp_last", 64'(resp_last), 64'(e.l));
              chk("resp_is_write", 64'(resp_is_write), 64'(e.w));
              last_resp.d = resp_data;
              last_resp.l = resp_last;
              last_resp.w = resp_is_write;
              pops++;
              if (pops == 1)
                first_pop_cyc = cyc;
              last_pop_cyc = cyc;
              if (e.l && exp_q.size() == 0)
                m_busy = 1'b0;
            end
          end
        end
        if (req_valid && req_ready) begin
          acc_cyc      = cyc;
          first_rv_cyc = -1;
          pops         = 0;
          m_busy       = 1'b1;
          b = 64'($signed(req_addr - BASE) >>> 3);
          if (req_wen) begin
            m_wactive = 1'b1;
            m_widx    = b;
            m_wleft   = int'(req_len);
          end else begin
            for (int k = 0; k <= int'(req_len); k++) begin
              wi = b + 64'(k);
              exp_q.push_back('{d: mdl[wi[7:0]],
                                l: k == int'(req_len),
                                w: 1'b0});
            end
          end
        end
      end
    end
  end

  task automatic send_req(input logic [63:0] a, input logic wen,
                          input logic [7:0] len);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wen   = wen;
    req_len   = len;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clock);
      #1;
      if (req_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL req_accept: got no handshake expected one");
    end
    req_valid = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [31:0] strbs,
                             input logic [7:0] seed);
    bit ok;
    for (int k = 0; k < n; k++) begin
      w_valid = 1'b1;
      w_data  = {16'hC0DE, seed, 8'(k), 32'h1357_9BDF};
      w_strb  = strbs[8*k +: 8];
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clock);
        #1;
        if (w_ready) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL w_accept: got no handshake expected one");
      end
      @(posedge clock);
      #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && !m_busy && !m_wactive) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d pending expected 0",
               exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    ram_init   = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wen    = 1'b0;
    req_len    = '0;
    w_valid    = 1'b0;
    w_data     = '0;
    w_strb     = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("rst_ram_rIdx", ram_rIdx, 64'd0);
    chk("rst_ram_wIdx", ram_wIdx, 64'd0);
    chk("rst_ram_wdata", ram_wdata, 64'd0);
    chk("rst_ram_wmask", ram_wmask, 64'd0);
    ram_init = 1'b0;
    reset    = 1'b0;
    @(posedge clock);
    #1;

    // single read of idx 0
    send_req(BASE, 1'b0, 8'd0);
    wait_idle(50);
    chk("rd1_latency", 64'(first_rv_cyc - acc_cyc), 64'd3);
    chk("rd1_ridx", ridx_log[(acc_cyc + 1) % 1024], 64'd0);
    chk("rd1_data", last_resp.d, 64'hDEAD_BEEF_0000_0001);
    chk("rd1_last", 64'(last_resp.l), 64'd1);
    chk("rd1_is_write", 64'(last_resp.w), 64'd0);

    // 4-beat write at idx 2, last beat low-half strobes
    widx_q.delete();
    wmask_q.delete();
    send_req(BASE + 64'h10, 1'b1, 8'd3);
    write_beats(4, 32'h0FFF_FFFF, 8'h01);
    wait_idle(50);
    chk("wr_beats", 64'(widx_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < widx_q.size(); i++)
      chk("wr_widx", widx_q[i], 64'd2 + 64'(i));
    if (wmask_q.size() == 4) begin
      chk("wr_mask0", wmask_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wr_mask3", wmask_q[3], 64'h0000_0000_FFFF_FFFF);
    end
    chk("wr_resp_lat", 64'(first_rv_cyc - last_wbeat_cyc), 64'd2);
    chk("wr_resp_last", 64'(last_resp.l), 64'd1);
    chk("wr_resp_is_write", 64'(last_resp.w), 64'd1);
    chk("wr_resp_data", last_resp.d, 64'd0);
    chk("wr_pops", 64'(pops), 64'd1);

    send_req(BASE + 64'h10, 1'b0, 8'd3);
    wait_idle(50);

    // backpressure: 16 beats from idx 10
    resp_ready = 1'b0;
    send_req(BASE + 64'd80, 1'b0, 8'd15);
    repeat (10) @(posedge clock);
    #1;
    chk("bp_stall_ridx", ram_rIdx, 64'd13);
    chk("bp_resp_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    wait_idle(200);
    chk("bp_pops", 64'(pops), 64'd16);
    chk("bp_last", 64'(last_resp.l), 64'd1);

    // throughput: 256 beats from idx 100
    send_req(BASE + 64'd800, 1'b0, 8'd255);
    wait_idle(600);
    chk("tp_pops", 64'(pops), 64'd256);
    chk("tp_span", 64'(last_pop_cyc - first_pop_cyc), 64'd255);

    // reset during beat 2 of a 4-beat write at idx 20
    send_req(BASE + 64'd160, 1'b1, 8'd3);
    w_valid = 1'b1;
    w_strb  = 8'hFF;
    w_data  = 64'hAAAA_0000_0000_0000;
    @(posedge clock);
    #1;
    w_data = 64'hAAAA_0000_0000_0001;
    @(posedge clock);
    #1;
    w_data = 64'hAAAA_0000_0000_0002;
    #1;
    chk("mr_wen_beat2", 64'(ram_wen), 64'd1);
    reset = 1'b1;
    #1;
    chk("mr_wen_async", 64'(ram_wen), 64'd0);
    chk("mr_w_ready", 64'(w_ready), 64'd0);
    chk("mr_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clock);
    #1;
    w_valid = 1'b0;
    reset   = 1'b0;
    @(negedge clock);
    #1;
    chk("mr_req_ready", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clock);
    #1;
    chk("mr_no_resp", 64'(resp_valid), 64'd0);
    @(posedge clock);
    #1;
    send_req(BASE + 64'd160, 1'b0, 8'd3);
    wait_idle(50);

    // address alignment and wrap
    send_req(BASE + 64'h7, 1'b0, 8'd0);
    wait_idle(50);
    chk("al_ridx", ridx_log[(acc_cyc + 1) % 1024], 64'd0);
    send_req(BASE - 64'd8, 1'b0, 8'd1);
    wait_idle(50);
    chk("wrap_ridx0", ridx_log[(acc_cyc + 1) % 1024],
        64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_ridx1", ridx_log[(acc_cyc + 2) % 1024], 64'd0);
    chk("wrap_pops", 64'(pops), 64'd2);

    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
